// File: rtl/hy_pingpong_loader_if.sv
// Load, handshake and read bus of the H/Y ping-pong loader.
interface hy_pingpong_loader_if #(
  parameter int N    = 32,
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int YLEN = 8
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int YW = (YLEN > 1) ? $clog2(YLEN) : 1;

  logic                 frame_start;
  logic                 H_in_valid;
  logic signed [N-1:0]  H_in_r;
  logic signed [N-1:0]  H_in_i;
  logic                 Y_in_valid;
  logic signed [N-1:0]  Y_in_r;
  logic signed [N-1:0]  Y_in_i;
  logic                 wr_ready;
  logic                 err_overflow;
  logic                 calc_start;
  logic                 bank_valid;
  logic                 rd_bank_id;
  logic [RW-1:0]        h_rd_row;
  logic [CW-1:0]        h_rd_col;
  logic signed [N-1:0]  h_rd_r;
  logic signed [N-1:0]  h_rd_i;
  logic [YW-1:0]        y_rd_addr;
  logic signed [N-1:0]  y_rd_r;
  logic signed [N-1:0]  y_rd_i;
  logic                 calc_done;

  modport master (
    output frame_start, H_in_valid, H_in_r, H_in_i, Y_in_valid, Y_in_r, Y_in_i,
    output h_rd_row, h_rd_col, y_rd_addr, calc_done,
    input  wr_ready, err_overflow, calc_start, bank_valid, rd_bank_id,
    input  h_rd_r, h_rd_i, y_rd_r, y_rd_i
  );

  modport slave (
    input  frame_start, H_in_valid, H_in_r, H_in_i, Y_in_valid, Y_in_r, Y_in_i,
    input  h_rd_row, h_rd_col, y_rd_addr, calc_done,
    output wr_ready, err_overflow, calc_start, bank_valid, rd_bank_id,
    output h_rd_r, h_rd_i, y_rd_r, y_rd_i
  );
endinterface

// File: rtl/hy_pingpong_loader.sv
// Ping-pong H/Y frame loader: one bank fills while the other is read by the
// compute engine; banks move EMPTY -> FILLING -> FULL -> READING -> EMPTY.
module hy_pingpong_loader #(
  parameter int N      = 32,
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int YLEN   = 8,
  parameter bit CONJ_Y = 1'b1
) (
  input  logic clk,
  input  logic rst,
  hy_pingpong_loader_if.slave bus
);
  localparam int HN  = ROWS * COLS;
  localparam int HA  = (HN > 1) ? $clog2(HN) : 1;
  localparam int YA  = (YLEN > 1) ? $clog2(YLEN) : 1;
  localparam int HCW = $clog2(HN + 1);
  localparam int YCW = $clog2(YLEN + 1);
  localparam logic signed [N-1:0] S_MAX = {1'b0, {(N-1){1'b1}}};
  localparam logic signed [N-1:0] S_MIN = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {EMPTY, FILLING, FULL, READING} bank_st_e;

  // Negation that maps the most negative code to the most positive one
  function automatic logic signed [N-1:0] neg_sat(input logic signed [N-1:0] x);
    return (x == S_MIN) ? S_MAX : -x;
  endfunction

  bank_st_e            bank_st_q [2];
  bank_st_e            bank_st_d [2];
  logic                wr_bank_q, wr_bank_d;
  logic                rd_bank_q, rd_bank_d;
  logic                bank_valid_q, bank_valid_d;
  logic                calc_start_q, calc_start_d;
  logic                err_q, err_d;
  logic [HCW-1:0]      h_cnt_q, h_cnt_d;
  logic [YCW-1:0]      y_cnt_q, y_cnt_d;
  logic signed [N-1:0] h_rd_r_q, h_rd_r_d, h_rd_i_q, h_rd_i_d;
  logic signed [N-1:0] y_rd_r_q, y_rd_r_d, y_rd_i_q, y_rd_i_d;

  logic signed [N-1:0] h_mem_r [2][HN];
  logic signed [N-1:0] h_mem_i [2][HN];
  logic signed [N-1:0] y_mem_r [2][YLEN];
  logic signed [N-1:0] y_mem_i [2][YLEN];

  logic                wr_ready, restart, h_acc, y_acc, frame_done;
  logic [HCW-1:0]      h_base;
  logic [YCW-1:0]      y_base;
  logic [HA-1:0]       h_ridx;
  logic signed [N-1:0] y_store_i;

  assign y_store_i = CONJ_Y ? neg_sat(bus.Y_in_i) : bus.Y_in_i;
  assign h_ridx    = HA'(32'(bus.h_rd_row) * 32'(COLS) + 32'(bus.h_rd_col));

  // Beat acceptance; a restart rewinds the write position to element 0
  always_comb begin
    wr_ready = (bank_st_q[wr_bank_q] == EMPTY) || (bank_st_q[wr_bank_q] == FILLING);
    restart  = bus.frame_start && wr_ready;
    h_base   = restart ? '0 : h_cnt_q;
    y_base   = restart ? '0 : y_cnt_q;
    h_acc    = bus.H_in_valid && wr_ready && (h_base < HCW'(HN));
    y_acc    = bus.Y_in_valid && wr_ready && (y_base < YCW'(YLEN));
  end

  // Bank state, counters, promotion to the reader and release
  always_comb begin
    bank_st_d    = bank_st_q;
    wr_bank_d    = wr_bank_q;
    rd_bank_d    = rd_bank_q;
    bank_valid_d = bank_valid_q;
    calc_start_d = 1'b0;
    err_d        = err_q | (bus.H_in_valid && !h_acc) | (bus.Y_in_valid && !y_acc);
    h_cnt_d      = h_base + HCW'(h_acc);
    y_cnt_d      = y_base + YCW'(y_acc);
    frame_done   = wr_ready && (h_cnt_d == HCW'(HN)) && (y_cnt_d == YCW'(YLEN));
    if (wr_ready) begin
      if (frame_done) begin
        bank_st_d[wr_bank_q] = FULL;
        wr_bank_d            = ~wr_bank_q;
        h_cnt_d              = '0;
        y_cnt_d              = '0;
      end else if (h_acc || y_acc) begin
        bank_st_d[wr_bank_q] = FILLING;
      end else if (restart) begin
        bank_st_d[wr_bank_q] = EMPTY;
      end
    end
    // The writer only touches EMPTY/FILLING banks, so this never collides
    if (bank_valid_q) begin
      if (bus.calc_done) begin
        bank_st_d[rd_bank_q] = EMPTY;
        bank_valid_d         = 1'b0;
        rd_bank_d            = ~rd_bank_q;
      end
    end else if (bank_st_q[rd_bank_q] == FULL) begin
      bank_st_d[rd_bank_q] = READING;
      bank_valid_d         = 1'b1;
      calc_start_d         = 1'b1;
    end
  end

  // Read mux from the current read bank; out-of-range addresses give zero
  always_comb begin
    h_rd_r_d = '0;
    h_rd_i_d = '0;
    y_rd_r_d = '0;
    y_rd_i_d = '0;
    if ((32'(bus.h_rd_row) < 32'(ROWS)) && (32'(bus.h_rd_col) < 32'(COLS))) begin
      h_rd_r_d = h_mem_r[rd_bank_q][h_ridx];
      h_rd_i_d = h_mem_i[rd_bank_q][h_ridx];
    end
    if (32'(bus.y_rd_addr) < 32'(YLEN)) begin
      y_rd_r_d = y_mem_r[rd_bank_q][bus.y_rd_addr];
      y_rd_i_d = y_mem_i[rd_bank_q][bus.y_rd_addr];
    end
  end

  // Control and read-data registers
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_st_q[0] <= EMPTY;
      bank_st_q[1] <= EMPTY;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      bank_valid_q <= 1'b0;
      calc_start_q <= 1'b0;
      err_q        <= 1'b0;
      h_cnt_q      <= '0;
      y_cnt_q      <= '0;
      h_rd_r_q     <= '0;
      h_rd_i_q     <= '0;
      y_rd_r_q     <= '0;
      y_rd_i_q     <= '0;
    end else begin
      bank_st_q    <= bank_st_d;
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      bank_valid_q <= bank_valid_d;
      calc_start_q <= calc_start_d;
      err_q        <= err_d;
      h_cnt_q      <= h_cnt_d;
      y_cnt_q      <= y_cnt_d;
      h_rd_r_q     <= h_rd_r_d;
      h_rd_i_q     <= h_rd_i_d;
      y_rd_r_q     <= y_rd_r_d;
      y_rd_i_q     <= y_rd_i_d;
    end
  end

  // Bank storage, written only into the current write bank
  always_ff @(posedge clk) begin
    if (h_acc) begin
      h_mem_r[wr_bank_q][HA'(h_base)] <= bus.H_in_r;
      h_mem_i[wr_bank_q][HA'(h_base)] <= bus.H_in_i;
    end
    if (y_acc) begin
      y_mem_r[wr_bank_q][YA'(y_base)] <= bus.Y_in_r;
      y_mem_i[wr_bank_q][YA'(y_base)] <= y_store_i;
    end
  end

  assign bus.wr_ready     = wr_ready;
  assign bus.err_overflow = err_q;
  assign bus.calc_start   = calc_start_q;
  assign bus.bank_valid   = bank_valid_q;
  assign bus.rd_bank_id   = rd_bank_q;
  assign bus.h_rd_r       = h_rd_r_q;
  assign bus.h_rd_i       = h_rd_i_q;
  assign bus.y_rd_r       = y_rd_r_q;
  assign bus.y_rd_i       = y_rd_i_q;
endmodule

// File: doc/hy_pingpong_loader.md
Name: hy_pingpong_loader

Overview:
- Parametrised successor to the single-bank H/Y load stage of the detector datapath.
- Captures one channel matrix H (ROWS x COLS complex) and one received block Y (YLEN complex) per frame into a ping-pong pair of banks.
- The compute engine reads a full bank while the next frame loads into the other bank.
- Start and release are controlled by an explicit start/done handshake, so loading of frame f+1 overlaps computation of frame f.

Parameters:
- N, 32, sample width (signed, real and imaginary each).
- ROWS, 4, H rows.
- COLS, 4, H columns.
- YLEN, 8, Y samples per frame.
- CONJ_Y, 1, 1 = store conj(Y), i.e. negate the imaginary part with saturation; 0 = store as-is.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- frame_start  in  1  pulse; aborts and restarts the frame in the current write bank.
- H_in_valid  in  1  H beat valid.
- H_in_r  in  N  H real.
- H_in_i  in  N  H imag.
- Y_in_valid  in  1  Y beat valid.
- Y_in_r  in  N  Y real.
- Y_in_i  in  N  Y imag.
- wr_ready  out  1  write bank can accept beats.
- err_overflow  out  1  sticky: a beat was offered while not accepted.
- calc_start  out  1  one-cycle pulse: a bank was handed to the reader.
- bank_valid  out  1  read bank holds a frame that is not yet released.
- rd_bank_id  out  1  index of the current read bank.
- h_rd_row  in  clog2(ROWS)  H read row.
- h_rd_col  in  clog2(COLS)  H read column.
- h_rd_r  out  N  registered H real.
- h_rd_i  out  N  registered H imag.
- y_rd_addr  in  clog2(YLEN)  Y read index.
- y_rd_r  out  N  registered Y real.
- y_rd_i  out  N  registered Y imag.
- calc_done  in  1  reader releases the current read bank.

Behaviour:
- Reset (synchronous, active-high):
  - Both banks EMPTY; wr_bank=0, rd_bank_id=0.
  - Counters cleared.
  - wr_ready=1; calc_start=0, bank_valid=0, err_overflow=0.
  - h_rd_*=0, y_rd_*=0.
  - Reset mid-frame or mid-read discards all data.
- Bank states: EMPTY -> FILLING (first accepted beat) -> FULL (frame complete) -> READING (promoted) -> EMPTY (calc_done).
- wr_ready=1 iff the write bank is EMPTY or FILLING.
- H load:
  - Beat accepted when H_in_valid && wr_ready && h_cnt<ROWS*COLS.
  - Row-major: the column counter wraps at COLS-1 and increments the row.
- Y load:
  - Beat accepted when Y_in_valid && wr_ready && y_cnt<YLEN; H and Y may arrive in the same cycle.
  - Stored imaginary part = CONJ_Y ? sat(-Y_in_i) : Y_in_i.
  - sat(-(-2^(N-1))) = 2^(N-1)-1.
- Frame complete:
  - Occurs when h_cnt==ROWS*COLS and y_cnt==YLEN after the edge that accepts the last beat.
  - At that same edge: bank -> FULL, wr_bank toggles, counters clear.
  - wr_ready for the next cycle reflects the state of the new write bank.
- Overflow:
  - Any valid beat not accepted (wr_ready=0, or its H/Y half is already full) is dropped and sets err_overflow, which stays set until rst.
- frame_start:
  - Clears the counters of the write bank, which returns to EMPTY.
  - Has no effect on FULL/READING banks.
  - If it coincides with a valid beat, the beat is accepted as element 0.
- Promotion:
  - When bank_valid=0 and bank rd_bank_id is FULL, the next edge sets it to READING, bank_valid=1, calc_start=1 for exactly one cycle.
  - Latency: last beat at edge k -> calc_start high in the cycle after edge k+1.
- Release:
  - calc_done while bank_valid=1: at that edge the bank -> EMPTY, bank_valid=0, rd_bank_id toggles.
  - If the other bank is FULL, it is promoted on the following edge (one idle cycle between frames).
  - calc_done while bank_valid=0 is ignored.
- Reads:
  - 1-cycle registered latency from the address inputs.
  - Data always comes from bank rd_bank_id regardless of bank_valid.
  - Out-of-range addresses (non-power-of-2 params) return 0.
- Simultaneous frame completion and calc_done are both honoured in the same edge.
  - Write and read banks never alias: the writer only writes a bank that is EMPTY/FILLING.

Test Plan:
- Single frame: reset, 16 H beats (value = index), 8 Y beats with Y_in_i=+5 -> calc_start pulse 2 cycles after the last beat; read (2,3) gives h_rd_r=11 one cycle later; y_rd_i=-5.
- Back-to-back: load frame A, load frame B while A is READING -> after B completes, wr_ready=0; beat offered -> err_overflow=1; calc_done -> B promoted next+1 cycle, rd_bank_id=1.
- Conjugation saturation: Y_in_i=0x80000000 with CONJ_Y=1 -> stored 0x7FFFFFFF; with CONJ_Y=0 -> 0x80000000.
- Abort: 7 H beats, then frame_start with a valid beat -> that beat reads back at (0,0); 15 more H + 8 Y complete the frame normally.
- Interleaved H/Y same-cycle beats plus calc_done coinciding with frame completion -> both banks cycle correctly; no beat lost.
- Reset mid-read: assert rst while bank_valid=1 -> next cycle bank_valid=0, wr_ready=1, err_overflow=0, outputs 0.
